// File: rtl/spectro_sequencer.sv
// spectro_sequencer
//   Frame sequencer for the line-scan micro-spectrometer. Divides clk down to
//   the free-running sensor clock and produces the sensor start pulse. The
//   exposure is set by a register-file value. It then walks the readout window
//   and issues one ADC sample strobe and one pixel index per pixel.
//
// Ports:
//   clk          system clock
//   resetn       synchronous active-low reset
//   start        one-cycle frame request, accepted only while idle
//   continuous   restart a new frame straight after each frame_done while high
//   abort        one-cycle request to drop the current frame (no frame_done)
//   exposure     extra SST-high ticks beyond ST_MIN, latched at frame start
//   sclk         sensor clock; high while the divider is in its upper half
//   sst          sensor start; changes only at SCLK falling edges
//   pix_strobe   one-cycle ADC sample strobe, one clk after each readout tick
//   pix_index    pixel number, valid with pix_strobe
//   frame_start  one-cycle pulse as sst rises
//   frame_done   one-cycle pulse at the end of the tail
//   busy         high from sst rise through frame_done
module spectro_sequencer #(
    parameter int CLK_DIV = 8,
    parameter int ST_MIN  = 6,
    parameter int LEAD    = 88,
    parameter int NPIX    = 288,
    parameter int TAIL    = 10,
    parameter int IW      = 9
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          continuous,
    input  logic          abort,
    input  logic [31:0]   exposure,
    output logic          sclk,
    output logic          sst,
    output logic          pix_strobe,
    output logic [IW-1:0] pix_index,
    output logic          frame_start,
    output logic          frame_done,
    output logic          busy
);

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST_HIGH,
        S_LEAD,
        S_READ,
        S_TAIL
    } state_t;

    state_t        state, state_n;
    logic [DW-1:0] div, div_n;
    logic          tick;
    // 33 bits so that ST_MIN + 32'hFFFFFFFF cannot wrap
    logic [32:0]   cnt, cnt_n;
    logic          pending, pending_n;
    logic          launch;
    logic          sst_n, busy_n, pix_strobe_n, frame_start_n, frame_done_n;
    logic [IW-1:0] pix_index_n;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div         <= '0;
            sclk        <= 1'b0;
            state       <= S_IDLE;
            cnt         <= '0;
            pending     <= 1'b0;
            sst         <= 1'b0;
            busy        <= 1'b0;
            pix_strobe  <= 1'b0;
            pix_index   <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            div         <= div_n;
            // registered from the next divider value so sclk lines up with div
            sclk        <= (div_n >= DW'(CLK_DIV / 2));
            state       <= state_n;
            cnt         <= cnt_n;
            pending     <= pending_n;
            sst         <= sst_n;
            busy        <= busy_n;
            pix_strobe  <= pix_strobe_n;
            pix_index   <= pix_index_n;
            frame_start <= frame_start_n;
            frame_done  <= frame_done_n;
        end
    end

    always_comb begin
        tick          = (div == DW'(CLK_DIV - 1));
        div_n         = tick ? '0 : div + 1'b1;
        state_n       = state;
        cnt_n         = cnt;
        pending_n     = pending;
        sst_n         = sst;
        busy_n        = busy;
        pix_strobe_n  = 1'b0;
        pix_index_n   = pix_index;
        frame_start_n = 1'b0;
        frame_done_n  = 1'b0;
        launch        = 1'b0;

        if (state == S_IDLE && start) begin
            pending_n = 1'b1;
        end

        // index advances in the strobe cycle itself, after it has been sampled
        if (pix_strobe && state == S_READ) begin
            pix_index_n = pix_index + 1'b1;
        end

        if (tick) begin
            case (state)
                S_IDLE: begin
                    launch = pending;
                end
                S_ST_HIGH: begin
                    if (cnt == 33'd1) begin
                        sst_n   = 1'b0;
                        cnt_n   = 33'(LEAD);
                        state_n = S_LEAD;
                    end else begin
                        cnt_n = cnt - 33'd1;
                    end
                end
                S_LEAD: begin
                    if (cnt == 33'd1) begin
                        pix_index_n = '0;
                        state_n     = S_READ;
                    end else begin
                        cnt_n = cnt - 33'd1;
                    end
                end
                S_READ: begin
                    pix_strobe_n = 1'b1;
                    if (pix_index == IW'(NPIX - 1)) begin
                        cnt_n   = 33'(TAIL);
                        state_n = S_TAIL;
                    end
                end
                S_TAIL: begin
                    if (cnt == 33'd1) begin
                        frame_done_n = 1'b1;
                        if (continuous) begin
                            launch = 1'b1;
                        end else begin
                            busy_n  = 1'b0;
                            state_n = S_IDLE;
                        end
                    end else begin
                        cnt_n = cnt - 33'd1;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end

        // shared by the idle start and the back-to-back continuous restart
        if (launch) begin
            cnt_n         = {1'b0, exposure} + 33'(ST_MIN);
            sst_n         = 1'b1;
            busy_n        = 1'b1;
            frame_start_n = 1'b1;
            pending_n     = 1'b0;
            state_n       = S_ST_HIGH;
        end

        if (abort) begin
            state_n       = S_IDLE;
            sst_n         = 1'b0;
            busy_n        = 1'b0;
            pix_strobe_n  = 1'b0;
            frame_start_n = 1'b0;
            frame_done_n  = 1'b0;
            pending_n     = 1'b0;
        end
    end

endmodule
